// File: rtl/set_ctrl.sv
// set_ctrl: CPU-facing initiator for one set over its ch1 port. Read lookup,
// miss fetch and fill, write-allocate with write-through, and an eviction watchdog.
//
// state    | meaning
// IDLE     | ready for a CPU request
// LOOKUP   | set_read asserted for one cycle
// CHECK    | set hit/data from the lookup are valid
// MEM_RD   | line fetch request held until accepted
// MEM_WAIT | waiting for fetched data
// FILL     | set_write held until the set reports the line present
// MEM_WR   | write-through request held until accepted
// RESP     | one-cycle completion pulse
module set_ctrl #(
   parameter int ADDR_WIDTH    = 8,
   parameter int LINE_WIDTH    = 32,
   parameter int K             = 2,
   parameter int EVICT_TIMEOUT = K + 3
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LINE_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [LINE_WIDTH-1:0] resp_rdata,
   output logic                  err,
   output logic                  set_enable,
   output logic [ADDR_WIDTH-1:0] set_addr,
   output logic [LINE_WIDTH-1:0] set_val,
   output logic                  set_read,
   output logic                  set_write,
   input  logic                  set_hit,
   input  logic [LINE_WIDTH-1:0] set_out_val,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_req_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic                  mem_resp_valid,
   input  logic [LINE_WIDTH-1:0] mem_rdata
);
   typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, MEM_RD, MEM_WAIT, FILL, MEM_WR, RESP} state_t;

   localparam int CNT_W = $clog2(EVICT_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] WDOG_LOAD = CNT_W'(EVICT_TIMEOUT - 1);

   state_t                state, state_nx;
   logic [CNT_W-1:0]      wdog, wdog_nx;
   logic                  is_write, is_write_nx;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_nx;
   logic                  req_ready_nx, resp_valid_nx, err_nx, set_read_nx, set_write_nx;
   logic                  mem_req_valid_nx, mem_req_write_nx;
   logic [LINE_WIDTH-1:0] resp_rdata_nx, set_val_nx, mem_wdata_nx;
   logic [ADDR_WIDTH-1:0] set_addr_nx, mem_addr_nx;
   logic                  fill_done;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state         <= IDLE;
         wdog          <= '0;
         is_write      <= 1'b0;
         wdata_q       <= '0;
         req_ready     <= 1'b1;
         resp_valid    <= 1'b0;
         resp_rdata    <= '0;
         err           <= 1'b0;
         set_enable    <= 1'b0;
         set_addr      <= '0;
         set_val       <= '0;
         set_read      <= 1'b0;
         set_write     <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_req_write <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
      end else begin
         state         <= state_nx;
         wdog          <= wdog_nx;
         is_write      <= is_write_nx;
         wdata_q       <= wdata_nx;
         req_ready     <= req_ready_nx;
         resp_valid    <= resp_valid_nx;
         resp_rdata    <= resp_rdata_nx;
         err           <= err_nx;
         set_enable    <= 1'b1;
         set_addr      <= set_addr_nx;
         set_val       <= set_val_nx;
         set_read      <= set_read_nx;
         set_write     <= set_write_nx;
         mem_req_valid <= mem_req_valid_nx;
         mem_req_write <= mem_req_write_nx;
         mem_addr      <= mem_addr_nx;
         mem_wdata     <= mem_wdata_nx;
      end
   end

   always_comb begin
      state_nx         = state;
      wdog_nx          = wdog;
      is_write_nx      = is_write;
      wdata_nx         = wdata_q;
      req_ready_nx     = req_ready;
      resp_valid_nx    = 1'b0;
      resp_rdata_nx    = resp_rdata;
      err_nx           = err;
      set_addr_nx      = set_addr;
      set_val_nx       = set_val;
      set_read_nx      = 1'b0;
      set_write_nx     = set_write;
      mem_req_valid_nx = mem_req_valid;
      mem_req_write_nx = mem_req_write;
      mem_addr_nx      = mem_addr;
      mem_wdata_nx     = mem_wdata;
      fill_done        = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               req_ready_nx = 1'b0;
               is_write_nx  = req_write;
               wdata_nx     = req_wdata;
               set_addr_nx  = req_addr;
               if (req_write) begin
                  set_val_nx   = req_wdata;
                  set_write_nx = 1'b1;
                  wdog_nx      = WDOG_LOAD;
                  state_nx     = FILL;
               end else begin
                  set_read_nx = 1'b1;
                  state_nx    = LOOKUP;
               end
            end
         end
         LOOKUP: state_nx = CHECK;
         CHECK: begin
            if (set_hit) begin
               resp_rdata_nx = set_out_val;
               resp_valid_nx = 1'b1;
               state_nx      = RESP;
            end else begin
               mem_req_valid_nx = 1'b1;
               mem_req_write_nx = 1'b0;
               mem_addr_nx      = set_addr;
               state_nx         = MEM_RD;
            end
         end
         MEM_RD: begin
            if (mem_req_ready) begin
               mem_req_valid_nx = 1'b0;
               state_nx         = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (mem_resp_valid) begin
               resp_rdata_nx = mem_rdata;
               set_val_nx    = mem_rdata;
               set_write_nx  = 1'b1;
               wdog_nx       = WDOG_LOAD;
               state_nx      = FILL;
            end
         end
         FILL: begin
            // set_hit in the first FILL cycle predates the write and is stale
            if (set_hit && wdog != WDOG_LOAD) begin
               fill_done = 1'b1;
            end else if (wdog == '0) begin
               fill_done = 1'b1;
               err_nx    = 1'b1;
            end else begin
               wdog_nx = wdog - 1'b1;
            end
            if (fill_done) begin
               set_write_nx = 1'b0;
               if (is_write) begin
                  mem_req_valid_nx = 1'b1;
                  mem_req_write_nx = 1'b1;
                  mem_addr_nx      = set_addr;
                  mem_wdata_nx     = wdata_q;
                  state_nx         = MEM_WR;
               end else begin
                  resp_valid_nx = 1'b1;
                  state_nx      = RESP;
               end
            end
         end
         MEM_WR: begin
            if (mem_req_ready) begin
               mem_req_valid_nx = 1'b0;
               resp_rdata_nx    = wdata_q;
               resp_valid_nx    = 1'b1;
               state_nx         = RESP;
            end
         end
         RESP: begin
            req_ready_nx = 1'b1;
            state_nx     = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_set_ctrl.sv
// Bench for set_ctrl: a behavioural K-way CLOCK set, a randomized backing
// memory responder and a flat memory image as the reference for read data.
module tb_set_ctrl;
   localparam int AW  = 8;
   localparam int LW  = 32;
   localparam int K   = 2;
   localparam int TMO = K + 3;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          req_valid = 1'b0, req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [LW-1:0] req_wdata = '0;
   logic          req_ready, resp_valid, err, set_enable, set_read, set_write;
   logic [LW-1:0] resp_rdata, set_val, mem_wdata;
   logic [AW-1:0] set_addr, mem_addr;
   logic          set_hit = 1'b0;
   logic [LW-1:0] set_out_val = '0;
   logic          mem_req_valid, mem_req_write;
   logic          mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
   logic [LW-1:0] mem_rdata = '0;

   always #5 clock = ~clock;

   set_ctrl #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .K(K), .EVICT_TIMEOUT(TMO)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .err(err),
      .set_enable(set_enable), .set_addr(set_addr), .set_val(set_val),
      .set_read(set_read), .set_write(set_write),
      .set_hit(set_hit), .set_out_val(set_out_val),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_write(mem_req_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
   );

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // behavioural set: registered hit, CLOCK replacement, no reset
   bit          s_vld[K];
   bit [AW-1:0] s_tag[K];
   bit [LW-1:0] s_val[K];
   bit          s_ref[K];
   int          hand = 0, evictions = 0;
   bit          stub_stuck = 1'b0;

   function automatic int find_way(input logic [AW-1:0] a);
      for (int i = 0; i < K; i++) if (s_vld[i] && s_tag[i] == a) return i;
      return -1;
   endfunction

   function automatic int find_free();
      for (int i = 0; i < K; i++) if (!s_vld[i]) return i;
      return -1;
   endfunction

   always @(posedge clock) begin
      set_hit <= 1'b0;
      if (set_enable && set_read) begin
         if (find_way(set_addr) >= 0) begin
            set_hit                     <= 1'b1;
            set_out_val                 <= s_val[find_way(set_addr)];
            s_ref[find_way(set_addr)]   <= 1'b1;
         end
      end else if (set_enable && set_write && !stub_stuck) begin
         if (find_way(set_addr) >= 0) begin
            s_val[find_way(set_addr)] <= set_val;
            s_ref[find_way(set_addr)] <= 1'b1;
            set_hit                   <= 1'b1;
         end else if (find_free() >= 0) begin
            s_vld[find_free()] <= 1'b1;
            s_tag[find_free()] <= set_addr;
            s_val[find_free()] <= set_val;
            s_ref[find_free()] <= 1'b1;
            set_hit            <= 1'b1;
         end else if (s_ref[hand]) begin
            s_ref[hand] <= 1'b0;
            hand        <= (hand + 1) % K;
         end else begin
            s_tag[hand] <= set_addr;
            s_val[hand] <= set_val;
            s_ref[hand] <= 1'b1;
            hand        <= (hand + 1) % K;
            set_hit     <= 1'b1;
            evictions   <= evictions + 1;
         end
      end
   end

   logic [LW-1:0] bk_mem[256];
   logic [LW-1:0] ref_mem[256];
   logic [LW-1:0] r_data, r_wd;
   logic [AW-1:0] r_waddr, r_raddr;
   int            r_lat, r_nrd, r_nwr, r_wcyc, r_vcyc, r_unstable, r_busy_rdy;
   bit            r_got;

   task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d,
                         input int dly, input bit spam);
      int            hold, pend;
      logic [AW-1:0] pend_addr, held_addr;
      bit            seen;
      r_lat = 0; r_nrd = 0; r_nwr = 0; r_wcyc = 0; r_vcyc = 0;
      r_unstable = 0; r_busy_rdy = 0; r_got = 1'b0;
      hold = dly; pend = 0; seen = 1'b0; pend_addr = '0; held_addr = '0;
      @(negedge clock);
      chk("idle_ready", req_ready, 1);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      for (int cyc = 0; cyc < 100 && !r_got; cyc++) begin
         @(negedge clock);
         r_lat++;
         mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
         if (spam) begin
            req_addr  = AW'($urandom);
            req_write = 1'($urandom_range(0, 1));
         end else req_valid = 1'b0;
         if (req_ready) r_busy_rdy++;
         if (set_write) r_wcyc++;
         if (resp_valid) begin
            r_got  = 1'b1;
            r_data = resp_rdata;
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  mem_resp_valid = 1'b1;
                  mem_rdata      = bk_mem[pend_addr];
               end
            end
            if (mem_req_valid) begin
               r_vcyc++;
               if (!seen) begin
                  seen = 1'b1; held_addr = mem_addr;
               end else if (mem_addr !== held_addr) r_unstable++;
               if (hold > 0) hold--;
               else begin
                  mem_req_ready = 1'b1; seen = 1'b0; hold = dly;
                  if (mem_req_write) begin
                     r_nwr++; r_waddr = mem_addr; r_wd = mem_wdata;
                     bk_mem[mem_addr] = mem_wdata;
                  end else begin
                     r_nrd++; r_raddr = mem_addr;
                     pend = $urandom_range(1, 3); pend_addr = mem_addr;
                  end
               end
            end
         end
      end
      req_valid = 1'b0;
      chk("resp_seen", r_got, 1);
      @(negedge clock);
      chk("resp_one_cycle", resp_valid, 0);
      chk("ready_after", req_ready, 1);
   endtask

   task automatic run_op(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d,
                         input int dly, input bit spam, input bit exp_err);
      bit present;
      int exp_rd;
      present = (find_way(a) >= 0);
      exp_rd  = (!wr && !present) ? 1 : 0;
      do_req(wr, a, d, dly, spam);
      if (wr) begin
         ref_mem[a] = d;
         chk("wr_echo", r_data, d);
         chk("wr_mem_writes", r_nwr, 1);
         chk("wr_mem_addr", r_waddr, a);
         chk("wr_mem_data", r_wd, d);
      end else begin
         chk("rd_data", r_data, ref_mem[a]);
         chk("rd_mem_writes", r_nwr, 0);
         if (present) chk("rd_hit_latency", r_lat, 3);
         else chk("rd_fetch_addr", r_raddr, a);
      end
      chk("mem_reads", r_nrd, exp_rd);
      chk("mem_valid_held", r_vcyc, (r_nrd + r_nwr) * (dly + 1));
      chk("mem_addr_stable", r_unstable, 0);
      chk("busy_not_ready", r_busy_rdy, 0);
      chk("err", err, exp_err);
   endtask

   initial begin
      int            n, ev0, rv;
      logic [AW-1:0] miss_a;
      for (int i = 0; i < 256; i++) begin
         bk_mem[i]  = $urandom;
         ref_mem[i] = bk_mem[i];
      end
      bk_mem[8'h12]  = 32'hCAFEF00D;
      ref_mem[8'h12] = 32'hCAFEF00D;

      repeat (3) @(negedge clock);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_set_enable", set_enable, 0);
      chk("rst_err", err, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_set_rw", {set_read, set_write}, 0);
      reset_n = 1'b1;
      @(negedge clock);
      chk("set_enable_on", set_enable, 1);

      // CLOCK sweep on the third fill of a two-way set
      run_op(0, 8'h01, '0, 0, 0, 0);
      run_op(0, 8'h02, '0, 0, 0, 0);
      ev0 = evictions;
      run_op(0, 8'h03, '0, 0, 0, 0);
      chk("sweep_long_fill", r_wcyc > 2, 1);
      chk("one_eviction", evictions - ev0, 1);
      n = 0; miss_a = '0;
      for (int a = 1; a <= 3; a++) begin
         if (find_way(AW'(a)) >= 0) n++;
         else miss_a = AW'(a);
      end
      chk("lines_left", n, 2);
      run_op(0, miss_a, '0, 0, 0, 0);
      chk("evicted_misses", r_nrd, 1);

      run_op(0, 8'h12, '0, 1, 0, 0);
      chk("miss_data", r_data, 32'hCAFEF00D);
      chk("miss_one_read", r_nrd, 1);
      run_op(0, 8'h12, '0, 0, 0, 0);
      chk("hit_latency", r_lat, 3);
      chk("hit_no_mem", r_nrd + r_nwr, 0);

      run_op(1, 8'h34, 32'h11112222, 0, 0, 0);
      run_op(0, 8'h34, '0, 0, 0, 0);
      chk("wr_then_hit", r_nrd, 0);
      chk("wr_then_data", r_data, 32'h11112222);

      run_op(0, 8'h55, '0, 5, 1, 0);
      chk("ready_low_held", r_vcyc, 6);

      for (int i = 0; i < 60; i++)
         run_op(1'($urandom_range(0, 1)), AW'(8'h40 + $urandom_range(0, 5)), $urandom,
                $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);

      // set never confirms the write: watchdog fires, write-through still happens
      stub_stuck = 1'b1;
      run_op(1, 8'h70, 32'hA5A5_0F0F, 0, 0, 1);
      chk("tmo_fill_cycles", r_wcyc, TMO);
      stub_stuck = 1'b0;
      run_op(0, 8'h71, '0, 0, 0, 1);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      chk("err_cleared", err, 0);

      // reset while waiting for fetched data; the late response must be dropped
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h66;
      @(negedge clock);
      req_valid = 1'b0;
      for (int c = 0; c < 20 && !mem_req_valid; c++) @(negedge clock);
      chk("mw_req", mem_req_valid, 1);
      mem_req_ready = 1'b1;
      @(negedge clock);
      mem_req_ready = 1'b0;
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      chk("mw_idle_ready", req_ready, 1);
      chk("mw_idle_memreq", mem_req_valid, 0);
      @(negedge clock);
      mem_resp_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
      @(negedge clock);
      mem_resp_valid = 1'b0;
      rv = 0;
      repeat (6) begin
         @(negedge clock);
         if (resp_valid || set_write) rv++;
      end
      chk("mw_no_resp", rv, 0);
      chk("mw_ready", req_ready, 1);
      run_op(0, 8'h66, '0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got=running exp=finished");
      $fatal(1, "simulation time limit");
   end
endmodule
